// File: rtl/dram_read_return_tracker.sv
// dram_read_return_tracker: tracks issued DDR reads, captures each burst at its CAS due time and presents the assembled line.
// Define DRAM_RRT_CRIT_WORD_EN for critical-word-first beat placement and a line-aligned line_paddr_out.
module dram_read_return_tracker #(
  parameter int PADDR_BITS  = 64,
  parameter int COL_BITS    = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_LEN   = 8,
  parameter int CAS_LATENCY = 22,
  parameter int DEPTH       = 16,
  parameter int TS_BITS     = 16
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             issue_valid_in,
  output logic                             issue_ready_out,
  input  logic [PADDR_BITS-1:0]            issue_paddr_in,
  input  logic [COL_BITS-1:0]              issue_col_in,
  input  logic [DATA_WIDTH-1:0]            dq_in,
  output logic                             line_valid_out,
  input  logic                             line_ready_in,
  output logic [BURST_LEN*DATA_WIDTH-1:0]  line_data_out,
  output logic [PADDR_BITS-1:0]            line_paddr_out,
  output logic                             capturing_out,
  output logic [$clog2(DEPTH):0]           count_out,
  output logic                             err_out
);
  localparam int LB = $clog2(BURST_LEN);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, CAPTURE} state_t;
  state_t state, state_nxt;
  logic [TS_BITS-1:0] ts;
  logic [PADDR_BITS-1:0] q_paddr [DEPTH];
  logic [COL_BITS-1:0] q_col [DEPTH];
  logic [TS_BITS-1:0] q_due [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] q_cnt;
  logic [PADDR_BITS-1:0] cur_paddr, cur_paddr_fmt;
  logic [COL_BITS-1:0] cur_col;
  logic [LB-1:0] beat_cnt, widx;
  logic [BURST_LEN*DATA_WIDTH-1:0] line_buf, line_nxt;
  logic full, push, head_due, start, drop, last;
  logic unused_bits;
  // The entry being captured leaves the queue at its first beat but stays counted until its last beat.
  assign count_out = q_cnt + CW'(state == CAPTURE);
  assign full = count_out == CW'(DEPTH);
  assign issue_ready_out = !full;
  assign push = issue_valid_in && !full;
  assign head_due = q_cnt != '0 && q_due[head] == ts;
  assign start = head_due && state == IDLE;
  assign drop = head_due && state == CAPTURE;
  assign last = state == CAPTURE && beat_cnt == LB'(BURST_LEN - 1);
  assign unused_bits = ^{issue_col_in, cur_col, cur_paddr};
`ifdef DRAM_RRT_CRIT_WORD_EN
  assign widx = (state == IDLE ? q_col[head][LB-1:0] : cur_col[LB-1:0]) + beat_cnt;
  assign cur_paddr_fmt = {cur_paddr[PADDR_BITS-1:LB], LB'(0)};
`else
  assign widx = beat_cnt;
  assign cur_paddr_fmt = cur_paddr;
`endif
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= state_nxt;
  // Finishing a burst drops to IDLE; IDLE samples combinationally, so a head due next cycle loses no beat.
  always_comb state_nxt = start ? CAPTURE : last ? IDLE : state;
  always_comb capturing_out = start || state == CAPTURE;
  always_comb begin
    line_nxt = line_buf;
    line_nxt[widx*DATA_WIDTH +: DATA_WIDTH] = dq_in;
  end
  always_ff @(posedge clk_in)
    if (push) begin
      q_paddr[tail] <= issue_paddr_in;
      q_col[tail]   <= issue_col_in;
      q_due[tail]   <= ts + TS_BITS'(CAS_LATENCY);
    end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      ts             <= '0;
      head           <= '0;
      tail           <= '0;
      q_cnt          <= '0;
      beat_cnt       <= '0;
      cur_paddr      <= '0;
      cur_col        <= '0;
      line_buf       <= '0;
      line_valid_out <= 1'b0;
      line_data_out  <= '0;
      line_paddr_out <= '0;
      err_out        <= 1'b0;
    end else begin
      ts <= ts + TS_BITS'(1);
      if (push) tail <= tail + PW'(1);
      if (head_due) head <= head + PW'(1);
      q_cnt <= q_cnt + CW'(push) - CW'(head_due);
      if (start) begin
        cur_paddr <= q_paddr[head];
        cur_col   <= q_col[head];
      end
      if (capturing_out) begin
        beat_cnt <= beat_cnt + LB'(1);
        line_buf <= line_nxt;
      end
      if (last) begin
        line_valid_out <= 1'b1;
        line_data_out  <= line_nxt;
        line_paddr_out <= cur_paddr_fmt;
      end else if (line_ready_in) line_valid_out <= 1'b0;
      if ((issue_valid_in && full) || drop || (last && line_valid_out && !line_ready_in)) err_out <= 1'b1;
    end
endmodule

// File: tb/tb_dram_read_return_tracker.sv
// tb_dram_read_return_tracker: random and directed stimulus checked against an entry-list model of the read tracker.
module tb_dram_read_return_tracker;
  localparam int PA = 64, CB = 4, DW = 64, BL = 8, CL = 22, DEPTH = 16, TSB = 6, LW = BL * DW;
`ifdef DRAM_RRT_CRIT_WORD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic issue_valid_in = 1'b0, line_ready_in = 1'b0;
  logic issue_ready_out, line_valid_out, capturing_out, err_out;
  logic [PA-1:0] issue_paddr_in = '0, line_paddr_out;
  logic [CB-1:0] issue_col_in = '0;
  logic [DW-1:0] dq_in = '0;
  logic [LW-1:0] line_data_out;
  logic [$clog2(DEPTH):0] count_out;
  always #5 clk_in = ~clk_in;
  dram_read_return_tracker #(
    .PADDR_BITS(PA), .COL_BITS(CB), .DATA_WIDTH(DW), .BURST_LEN(BL),
    .CAS_LATENCY(CL), .DEPTH(DEPTH), .TS_BITS(TSB)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
    .issue_paddr_in(issue_paddr_in), .issue_col_in(issue_col_in), .dq_in(dq_in),
    .line_valid_out(line_valid_out), .line_ready_in(line_ready_in),
    .line_data_out(line_data_out), .line_paddr_out(line_paddr_out),
    .capturing_out(capturing_out), .count_out(count_out), .err_out(err_out)
  );
  int checks = 0, failures = 0;
  int c, ne, busy_until, last_iss;
  int e_issue [1024], e_due [1024], e_retire [1024];
  bit e_cap [1024];
  logic [PA-1:0] e_paddr [1024];
  logic [CB-1:0] e_col [1024];
  logic [DW-1:0] dq_hist [2048];
  bit mvalid, merr;
  logic [LW-1:0] mdata;
  logic [PA-1:0] mpaddr;
  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, LW'(line_valid_out), '0);
    chk({tag, "_err"}, LW'(err_out), '0);
    chk({tag, "_capt"}, LW'(capturing_out), '0);
    chk({tag, "_ready"}, LW'(issue_ready_out), LW'(1));
    chk({tag, "_count"}, LW'(count_out), '0);
    chk({tag, "_data"}, line_data_out, '0);
    chk({tag, "_paddr"}, LW'(line_paddr_out), '0);
  endtask
  task automatic model_reset();
    c = 0; ne = 0; busy_until = -100; last_iss = -100;
    mvalid = 0; merr = 0; mdata = '0; mpaddr = '0;
  endtask
  // Word slot that beat k of a burst lands in.
  function automatic int slot(input logic [CB-1:0] col, input int k);
    return (k + (CRIT ? int'(col) : 0)) % BL;
  endfunction
  // One clock cycle: called just after a falling edge, returns at the next falling edge.
  task automatic run_cycle(input bit iv, input logic [PA-1:0] pa, input logic [CB-1:0] col,
                           input logic [DW-1:0] dq, input bit rdy);
    int alive, done;
    bit cap_exp, err_ev;
    logic [LW-1:0] line;
    issue_valid_in = iv; issue_paddr_in = pa; issue_col_in = col; dq_in = dq; line_ready_in = rdy;
    dq_hist[c] = dq;
    alive = 0; done = -1; cap_exp = 0; err_ev = 0;
    for (int i = 0; i < ne; i++) begin
      if (e_issue[i] < c && e_retire[i] >= c) alive++;
      if (e_cap[i] && e_due[i] <= c && c <= e_retire[i]) cap_exp = 1;
      if (e_cap[i] && e_retire[i] == c) done = i;
      if (!e_cap[i] && e_due[i] == c) err_ev = 1;
    end
    #1;
    chk("count", LW'(count_out), LW'(alive));
    chk("issue_ready", LW'(issue_ready_out), LW'(alive < DEPTH));
    chk("capturing", LW'(capturing_out), LW'(cap_exp));
    if (iv) begin
      if (alive < DEPTH) begin
        e_issue[ne] = c; e_due[ne] = c + CL; e_paddr[ne] = pa; e_col[ne] = col;
        e_cap[ne] = e_due[ne] > busy_until;
        e_retire[ne] = e_cap[ne] ? e_due[ne] + BL - 1 : e_due[ne];
        if (e_cap[ne]) busy_until = e_retire[ne];
        ne++;
      end else err_ev = 1;
    end
    if (done >= 0) begin
      line = mdata;
      for (int k = 0; k < BL; k++) line[slot(e_col[done], k)*DW +: DW] = dq_hist[e_due[done] + k];
      if (mvalid && !rdy) err_ev = 1;
      mvalid = 1; mdata = line;
      mpaddr = CRIT ? e_paddr[done] & ~PA'(BL - 1) : e_paddr[done];
    end else if (rdy) mvalid = 0;
    if (err_ev) merr = 1;
    @(posedge clk_in); #1;
    chk("line_valid", LW'(line_valid_out), LW'(mvalid));
    chk("err", LW'(err_out), LW'(merr));
    chk("line_data", line_data_out, mdata);
    chk("line_paddr", LW'(line_paddr_out), LW'(mpaddr));
    c++;
    @(negedge clk_in);
  endtask
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  initial begin
    bit iv;
    model_reset();
    repeat (2) @(negedge clk_in);
    #1 chk_reset("rst0");
    rst_in = 1'b0;
    for (int i = 0; i < 60; i++)
      run_cycle(c == 10, 64'h40, 4'd5, (c >= 32 && c < 40) ? 64'(c - 32) : rnd64(), 1'b1);
    for (int w = 0; w < BL; w++)
      chk("single_word", LW'(line_data_out[w*DW +: DW]), LW'((w - (CRIT ? 5 : 0)) & 7));
    chk("single_paddr", LW'(line_paddr_out), LW'(64'h40));
    for (int i = 0; i < 600; i++) begin
      iv = (c - last_iss >= BL) && ($urandom_range(1, 0) == 1);
      if (iv) last_iss = c;
      run_cycle(iv, rnd64(), 4'($urandom), rnd64(), $urandom_range(3, 0) != 0);
    end
    for (int i = 0; i < 40; i++) run_cycle(1'b0, '0, '0, rnd64(), 1'b1);
    run_cycle(1'b1, rnd64(), 4'($urandom), rnd64(), 1'b1);
    for (int i = 0; i < CL + 2; i++) run_cycle(1'b0, '0, '0, rnd64(), 1'b1);
    rst_in = 1'b1;
    #1 chk_reset("rst_mid");
    @(negedge clk_in);
    chk_reset("rst_hold");
    rst_in = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) run_cycle(c == 2, rnd64(), 4'($urandom), rnd64(), 1'b1);
    for (int i = 0; i < 400; i++)
      run_cycle($urandom_range(3, 0) != 0, rnd64(), 4'($urandom), rnd64(), $urandom_range(1, 0) == 1);
    for (int i = 0; i < 80; i++) run_cycle(1'b0, '0, '0, rnd64(), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
